// File: rtl/int_divider_58by34_pkg.sv
// Shared types and widths for the 58/34 iterative divider.
package int_divider_58by34_pkg;
  localparam int INT_DIV_A_W   = 24;
  localparam int INT_DIV_B_W   = 34;
  localparam int INT_DIV_P_W   = INT_DIV_A_W + INT_DIV_B_W;
  localparam int INT_DIV_CNT_W = $clog2(INT_DIV_A_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} int_div_state_t;
endpackage

// File: rtl/int_divider_58by34_step.sv
// One radix-2 restoring step: shift in a dividend bit, conditionally subtract divisor.
// Combinational, zero latency; no flow control.
module int_div_step #(
  parameter int B_W = 34
) (
  input  logic [B_W-1:0] i_r,
  input  logic           i_qin,
  input  logic [B_W-1:0] i_d,
  output logic [B_W-1:0] o_r_next,
  output logic           o_qbit
);
  logic [B_W:0] w_t;
  logic [B_W:0] w_diff;

  assign w_t      = {i_r, i_qin};
  assign w_diff   = w_t - {1'b0, i_d};
  assign o_qbit   = (w_t >= {1'b0, i_d});
  // Partial remainder stays below the divisor, so the top bit is always zero here.
  assign o_r_next = B_W'(o_qbit ? w_diff : w_t);
endmodule

// File: rtl/int_divider_58by34.sv
// Iterative 58/34 unsigned divider: 24-bit quotient, 34-bit remainder, one bit per cycle.
// Latency accept+25 (accept+1 on zero divisor/overflow); result held in DONE until out_ready.
module int_divider_58by34
  import int_divider_58by34_pkg::*;
#(
  parameter int A_W = INT_DIV_A_W,
  parameter int B_W = INT_DIV_B_W,
  parameter int P_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [P_W-1:0] dividend,
  input  logic [B_W-1:0] divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [A_W-1:0] quotient,
  output logic [B_W-1:0] remainder,
  output logic           div_zero,
  output logic           overflow
);
  localparam int CNT_W = $clog2(A_W);

  int_div_state_t r_state, w_state_nxt;
  logic [B_W-1:0]   r_d, r_r, w_r_nxt;
  logic [A_W-1:0]   r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_div_zero, r_overflow;
  logic             w_qbit, w_accept;
  logic [B_W-1:0]   w_hi;

  assign w_hi      = dividend[P_W-1:A_W];
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;

  assign quotient  = r_q;
  assign remainder = r_r;
  assign div_zero  = r_div_zero;
  assign overflow  = r_overflow;

  int_div_step #(.B_W(B_W)) u_step (
    .i_r      (r_r),
    .i_qin    (r_q[A_W-1]),
    .i_d      (r_d),
    .o_r_next (w_r_nxt),
    .o_qbit   (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_state_nxt = ((divisor == '0) || (w_hi >= divisor)) ? DONE : CALC;
      CALC: if (r_cnt == '0) w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d        <= '0;
      r_r        <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
      r_div_zero <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (r_state == IDLE && w_accept) begin
        r_d        <= divisor;
        r_div_zero <= 1'b0;
        r_overflow <= 1'b0;
        if (divisor == '0) begin
          r_div_zero <= 1'b1;
          r_q        <= '1;
          r_r        <= '0;
        end else if (w_hi >= divisor) begin
          r_overflow <= 1'b1;
          r_q        <= '1;
          r_r        <= '0;
        end else begin
          r_r   <= w_hi;
          r_q   <= dividend[A_W-1:0];
          r_cnt <= CNT_W'(A_W - 1);
        end
      end else if (r_state == CALC) begin
        r_r   <= w_r_nxt;
        r_q   <= {r_q[A_W-2:0], w_qbit};
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end
endmodule
